// File: rtl/avalon_pio_pkg.sv
// Register map and mode constants shared by the Avalon-MM GPIO port and its input path.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin input path: synchroniser chain, previous-value register, post-reset warm-up
// counter and the direction-gated edge vector used by the capture register.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] i_in_port,
    input  logic [DATA_WIDTH-1:0] i_dir,
    output logic [DATA_WIDTH-1:0] o_sync_in,
    output logic [DATA_WIDTH-1:0] o_edge
);

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;
    logic [2:0]            r_warm_cnt;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_edge_raw;
    logic                  w_warm;

    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_warm    = (r_warm_cnt == WARM_DONE);

    // Synchroniser chain, previous value and warm-up counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev     <= '0;
            r_warm_cnt <= 3'd0;
        end else begin
            r_sync[0] <= i_in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_in;
            if (!w_warm) begin
                r_warm_cnt <= r_warm_cnt + 3'd1;
            end else begin
                r_warm_cnt <= r_warm_cnt;
            end
        end
    end

    // Edge kind selected at build time
    always_comb begin
        w_edge_raw = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge_raw = w_sync_in & ~r_prev;
            EDGE_FALLING: w_edge_raw = ~w_sync_in & r_prev;
            EDGE_ANY:     w_edge_raw = w_sync_in ^ r_prev;
            default:      w_edge_raw = w_sync_in & ~r_prev;
        endcase
    end

    // Pins that were already high at reset release must not look like fresh edges
    always_comb begin
        if (w_warm) begin
            o_edge = w_edge_raw & ~i_dir;
        end else begin
            o_edge = '0;
        end
    end

    assign o_sync_in = w_sync_in;

endmodule

// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers and a maskable irq.
// Build option PIO_BITSET_EN adds OUTSET (4) and OUTCLEAR (5) atomic bit writes.
module avalon_pio_gpio
    import avalon_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    IRQ_TYPE    = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_cap;
    logic                  r_irq;

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_cap_clr;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_irq_next;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[DATA_WIDTH-1:0];

    pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_in_port (in_port),
        .i_dir     (r_dir),
        .o_sync_in (w_sync_in),
        .o_edge    (w_edge)
    );

    // Next output data: plain write, plus atomic set/clear when built in
    always_comb begin
        w_data_next = r_data_out;
        if (w_wr && (address == ADDR_DATA)) begin
            w_data_next = w_wdata;
        end
`ifdef PIO_BITSET_EN
        else if (w_wr && (address == ADDR_OUTSET)) begin
            w_data_next = r_data_out | w_wdata;
        end else if (w_wr && (address == ADDR_OUTCLR)) begin
            w_data_next = r_data_out & ~w_wdata;
        end
`endif
        else begin
            w_data_next = r_data_out;
        end
    end

    // Write-one-to-clear mask for the capture register
    always_comb begin
        if (w_wr && (address == ADDR_EDGECAP)) begin
            w_cap_clr = w_wdata;
        end else begin
            w_cap_clr = '0;
        end
    end

    // Interrupt condition by build-time mode
    always_comb begin
        if (IRQ_TYPE == IRQ_EDGE) begin
            w_irq_next = |(r_cap & r_mask);
        end else begin
            w_irq_next = |(w_sync_in & r_mask & ~r_dir);
        end
    end

    // Register file, capture and irq; a new edge outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_data_out <= w_data_next;
            if (w_wr && (address == ADDR_DIR)) begin
                r_dir <= w_wdata;
            end else begin
                r_dir <= r_dir;
            end
            if (w_wr && (address == ADDR_MASK)) begin
                r_mask <= w_wdata;
            end else begin
                r_mask <= r_mask;
            end
            r_cap <= (r_cap & ~w_cap_clr) | w_edge;
            r_irq <= w_irq_next;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:    w_rd = (w_sync_in & ~r_dir) | (r_data_out & r_dir);
            ADDR_DIR:     w_rd = r_dir;
            ADDR_MASK:    w_rd = r_mask;
            ADDR_EDGECAP: w_rd = r_cap;
            default:      w_rd = '0;
        endcase
    end

    assign readdata = 32'(w_rd);
    assign out_port = r_data_out;
    assign oe       = r_dir;
    assign irq      = r_irq;

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Two GPIO instances on one bus (32-bit rising/edge-irq and 8-bit any-edge/level-irq)
// checked every cycle against a pin-history model, plus directed literal expectations.
module tb_avalon_pio_gpio;

    localparam int SA = 2;
    localparam int SB = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic [31:0] in_a, out_a, oe_a;
    logic [7:0]  in_b, out_b, oe_b;
    logic        irq_a, irq_b;
    logic        cmp_en = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_pio_gpio #(
        .DATA_WIDTH (32), .RESET_VALUE (32'h0000_00A5), .EDGE_TYPE (0),
        .IRQ_TYPE (1), .SYNC_STAGES (SA)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (rd_a),
        .in_port (in_a), .out_port (out_a), .oe (oe_a), .irq (irq_a)
    );

    avalon_pio_gpio #(
        .DATA_WIDTH (8), .RESET_VALUE (8'h3C), .EDGE_TYPE (2),
        .IRQ_TYPE (0), .SYNC_STAGES (SB)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (rd_b),
        .in_port (in_b), .out_port (out_b), .oe (oe_b), .irq (irq_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_data [2];
    logic [31:0] m_dir  [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_cap  [2];
    logic        m_irq  [2];
    logic [31:0] m_hist [2][8];   // m_hist[k][j]: pin value sampled j+1 clocks ago
    int          m_n    [2];      // clocks since reset release

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic int c_s(input int k);
        return (k == 0) ? SA : SB;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_data[k] = (k == 0) ? 32'h0000_00A5 : 32'h0000_003C;
            m_dir[k]  = 32'h0;
            m_mask[k] = 32'h0;
            m_cap[k]  = 32'h0;
            m_irq[k]  = 1'b0;
            m_n[k]    = 0;
            for (int j = 0; j < 8; j++) m_hist[k][j] = 32'h0;
        end
    endtask

    task automatic model_step();
        logic [31:0] pin [2];
        logic [31:0] sync, prev, ed, wd, d, cap_n;
        logic        wr, irq_n;
        pin[0] = in_a;
        pin[1] = {24'h0, in_b};
        wr = chipselect & ~write_n;
        for (int k = 0; k < 2; k++) begin
            sync = m_hist[k][c_s(k)-1];
            prev = m_hist[k][c_s(k)];
            ed = (k == 0) ? (sync & ~prev) : (sync ^ prev);
            ed = ed & ~m_dir[k];
            if (m_n[k] < c_s(k) + 1) ed = 32'h0;
            wd = writedata & wmask(k);
            irq_n = (k == 0) ? |(m_cap[k] & m_mask[k]) : |(sync & m_mask[k] & ~m_dir[k]);
            cap_n = m_cap[k] | ed;
            if (wr && address == 3'd3) cap_n = (m_cap[k] & ~wd) | ed;
            d = m_data[k];
            if (wr) begin
                case (address)
                    3'd0: d = wd;
                    3'd1: m_dir[k] = wd;
                    3'd2: m_mask[k] = wd;
`ifdef PIO_BITSET_EN
                    3'd4: d = d | wd;
                    3'd5: d = d & ~wd;
`endif
                    default: ;
                endcase
            end
            m_data[k] = d;
            m_cap[k]  = cap_n;
            m_irq[k]  = irq_n;
            for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = pin[k] & wmask(k);
            if (m_n[k] < 100) m_n[k]++;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k);
        logic [31:0] sync;
        sync = m_hist[k][c_s(k)-1];
        case (address)
            3'd0:    return (sync & ~m_dir[k]) | (m_data[k] & m_dir[k]);
            3'd1:    return m_dir[k];
            3'd2:    return m_mask[k];
            3'd3:    return m_cap[k];
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (reset_n !== 1'b1) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("out_a", out_a, m_data[0]);
                check("oe_a",  oe_a,  m_dir[0]);
                check("irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
                check("rd_a",  rd_a,  exp_rd(0));
                check("out_b", {24'h0, out_b}, m_data[1]);
                check("oe_b",  {24'h0, oe_b},  m_dir[1]);
                check("irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
                check("rd_b",  rd_b,  exp_rd(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic read_a(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, rd_a, exp);
    endtask

    int          lat;
    logic [31:0] exp_bs;

    initial begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        in_a       = 32'h0;
        in_b       = 8'h0;
        repeat (3) tick();
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // reset defaults
        check("rst_out_a", out_a, 32'h0000_00A5);
        check("rst_oe_a", oe_a, 32'h0);
        check("rst_irq_a", {31'h0, irq_a}, 32'h0);
        check("rst_out_b", {24'h0, out_b}, 32'h0000_003C);
        read_a("rst_dir", 3'd1, 32'h0);
        read_a("rst_mask", 3'd2, 32'h0);
        read_a("rst_cap", 3'd3, 32'h0);

        // direction and mixed readback
        bus_write(3'd1, 32'h0000_FFFF);
        bus_write(3'd0, 32'h1234_5678);
        in_a = 32'hABCD_0000;
        repeat (SA + 1) tick();
        check("dir_out", out_a, 32'h1234_5678);
        check("dir_oe", oe_a, 32'h0000_FFFF);
        read_a("dir_rd_data", 3'd0, 32'hABCD_5678);

        // rising-edge capture and irq latency
        bus_write(3'd1, 32'h0);
        in_a = 32'h0;
        repeat (4) tick();
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd2, 32'h0000_0001);
        read_a("cap_clear", 3'd3, 32'h0);
        in_a = 32'h0000_0001;
        lat = 0;
        while (lat < 20 && irq_a !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        #1;
        check("irq_latency", 32'(lat), 32'(SA + 2));
        read_a("cap_set", 3'd3, 32'h0000_0001);

        // write-one-to-clear drops irq one clock later
        bus_write(3'd3, 32'h0000_0001);
        read_a("cap_w1c", 3'd3, 32'h0);
        tick();
        check("irq_clear", {31'h0, irq_a}, 32'h0);

        // set and clear on the same clock: set wins
        in_a = 32'h0;
        repeat (4) tick();
        in_a = 32'h0000_0001;
        repeat (SA + 3) tick();
        in_a = 32'h0;
        repeat (4) tick();
        check("irq_pre_sc", {31'h0, irq_a}, 32'h1);
        in_a = 32'h0000_0001;
        repeat (SA) tick();
        bus_write(3'd3, 32'h0000_0001);
        read_a("setclr_cap", 3'd3, 32'h0000_0001);
        repeat (2) tick();
        check("setclr_irq", {31'h0, irq_a}, 32'h1);

        // atomic set/clear (present only in the bit-set build)
`ifdef PIO_BITSET_EN
        exp_bs = 32'h00F0_000F;
`else
        exp_bs = 32'hF0F0_0000;
`endif
        bus_write(3'd0, 32'hF0F0_0000);
        bus_write(3'd4, 32'h0000_000F);
        bus_write(3'd5, 32'hF000_0000);
        check("bitset_out", out_a, exp_bs);
        read_a("bitset_rd4", 3'd4, 32'h0);

        // warm-up: pins high through reset release must not capture
        in_a = 32'hFFFF_FFFF;
        in_b = 8'hFF;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        read_a("warm_cap_a", 3'd3, 32'h0);
        check("warm_cap_b", rd_b, 32'h0);
        in_a = 32'h0;
        in_b = 8'h00;
        repeat (SB + 3) tick();
        read_a("fall_cap_a", 3'd3, 32'h0);
        check("fall_cap_b", rd_b, 32'h0000_00FF);

        // randomized traffic with occasional asynchronous resets
        repeat (400) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) in_a = in_a ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) in_a = $urandom;
            if ($urandom_range(0, 3) == 0) in_b = 8'($urandom);
            if (r < 35) begin
                bus_write(3'($urandom_range(0, 7)), $urandom);
            end else if (r < 37) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                reset_n = 1'b1;
            end else begin
                address = 3'($urandom_range(0, 7));
                tick();
            end
        end
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_pio_gpio.md
Name: avalon_pio_gpio

Overview:
Parametrised successor to the fixed 32-bit output-only PIO.
- Avalon-MM slave GPIO port: DATA_WIDTH bits, per-bit direction, input synchronisation, edge capture and a maskable interrupt.
- Sits between the HPS/Nios bus fabric and board pins (LEDs, switches, keys).
- Zero-wait-state reads and writes; readdata is combinational from registers, as in the output-only PIO.

Parameters:
- DATA_WIDTH, 32: port width, 1..32.
- RESET_VALUE, 0: out_port value after reset (DATA_WIDTH bits).
- EDGE_TYPE, 0: edge detected for capture. 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 0: 0 = level (synced input & mask), 1 = edge (capture & mask).
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 3: register index.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- readdata, output, 32: read data (combinational).
- in_port, input, DATA_WIDTH: asynchronous pin inputs.
- out_port, output, DATA_WIDTH: registered output data.
- oe, output, DATA_WIDTH: per-bit output enable (1 = drive pin).
- irq, output, 1: registered interrupt request, active-high.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Registers update on the clk edge where wr is high; writedata bits >= DATA_WIDTH are ignored.
- readdata = {0, mux(address)}, available in the same cycle. Bits >= DATA_WIDTH read 0. Unmapped addresses read 0, and writes to them are ignored.
- Register map:
  - 0 DATA: read = (sync_in & ~dir) | (data_out & dir); write sets data_out.
  - 1 DIRECTION: R/W dir.
  - 2 IRQMASK: R/W mask.
  - 3 EDGECAP: read returns cap; writing 1 to a bit clears it.
- Reset values: data_out = RESET_VALUE; dir = mask = cap = 0; sync pipeline = 0; irq = 0; warm-up counter = 0.
- Outputs: out_port = data_out; oe = dir.
- Input path: in_port passes through SYNC_STAGES flops to give sync_in; prev holds sync_in delayed one cycle.
- Edge detection:
  - rise = sync_in & ~prev; fall = ~sync_in & prev; edge is selected by EDGE_TYPE.
  - Edge detection is gated by dir: output bits never capture.
- Warm-up after reset: a counter counts SYNC_STAGES+1 cycles after reset deassertion. Until it saturates, edge detection is suppressed. This prevents spurious capture from pins already high at reset release.
- Capture: cap[i] sets on edge[i] and holds until cleared. If set and clear happen in the same cycle, set wins and the bit stays 1.
- Interrupt:
  - irq_next = |(sync_in & mask & ~dir) when IRQ_TYPE = 0, |(cap & mask) when IRQ_TYPE = 1.
  - irq is registered: one cycle after the condition.
  - Latency from a pin edge to irq is SYNC_STAGES+2 cycles (IRQ_TYPE = 1, mask set).
- Reset asserted mid-operation clears all state immediately (asynchronous). A capture pending at that moment is lost.

Optional Feature:
Macro: PIO_BITSET_EN.
- Defined: address 4 OUTSET (write: data_out |= writedata) and address 5 OUTCLEAR (write: data_out &= ~writedata) are present. Both read 0. Single-cycle atomic bit manipulation without read-modify-write.
- Not defined: addresses 4 and 5 are unmapped (writes ignored, reads 0).

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants: ADDR_DATA = 0, ADDR_DIR = 1, ADDR_MASK = 2, ADDR_EDGECAP = 3, ADDR_OUTSET = 4, ADDR_OUTCLR = 5.
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY and IRQ_LEVEL / IRQ_EDGE localparams.
- Sub-module pio_sync_edge (DATA_WIDTH, SYNC_STAGES, EDGE_TYPE): synchroniser, prev register, warm-up counter and edge vector output. The top level holds the register file, capture, irq and read mux.

Test Plan:
- Reset defaults: RESET_VALUE = 32'h0000_00A5, reset released -> out_port = 0xA5, oe = 0, irq = 0; read addr 1/2/3 -> 0.
- Direction and readback: write DIR = 0x0000_FFFF, DATA = 0x1234_5678, in_port = 0xABCD_0000 -> out_port = 0x1234_5678, oe = 0xFFFF, read DATA = 0xABCD_5678 (after SYNC_STAGES+1 cycles).
- Edge capture with IRQ_TYPE = 1, EDGE_TYPE = 0, MASK = 0x1: in_port bit0 0->1 -> EDGECAP = 0x1 and irq = 1 exactly SYNC_STAGES+2 cycles after the pin change. Write EDGECAP = 0x1 -> irq = 0 on the next cycle.
- Simultaneous set/clear: a bit0 rising edge coincides with an EDGECAP write of 0x1 -> EDGECAP reads 0x1 and irq stays 1.
- Warm-up: in_port = 0xFFFF_FFFF held through reset release -> EDGECAP stays 0; a later falling edge with EDGE_TYPE = 2 sets all bits.
- PIO_BITSET_EN defined: DATA = 0xF0F0_0000, OUTSET write 0x0000_000F, then OUTCLEAR write 0xF000_0000 -> out_port = 0x00F0_000F. Build without the macro -> same writes leave 0xF0F0_0000.
